// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display path: the 7-segment code table,
// the dark pattern and the slot FSM state type.
package hex_disp_pkg;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } slot_state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high g..a codes; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bc_hex.sv
// 4-bit to 7-segment hex decoder (bits 6..0 = g..a, active-high).
module bc_hex
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment code for the selected nibble.
  always_comb begin
    seg = HEX7_TABLE[nibble];
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex scan controller with shadow/display double buffering,
// frame-boundary commit and per-slot dead time.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).
module hex_scan_ctrl
  import hex_disp_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int PRESCALE    = 1000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [7:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(PRESCALE - DEAD_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);

  slot_state_t       state_r, state_nx_s;
  logic [CW-1:0]     cnt_r, cnt_nx_s;
  logic [DW-1:0]     digit_r, digit_nx_s;

  logic [VW-1:0]       sh_value_r, dsp_value_r, dsp_value_nx_s;
  logic [N_DIGITS-1:0] sh_dp_r, dsp_dp_r, dsp_dp_nx_s;
  logic [N_DIGITS-1:0] sh_blank_r, dsp_blank_r, dsp_blank_nx_s;
  logic                pending_r;

  logic                frame_end_s, frame_end_nx_s, commit_s, accept_s;
  logic [3:0]          nibble_s;
  logic [6:0]          hex_seg_s;
  logic                suppress_s;
  logic [7:0]          pattern_s;

  // Handshake and frame-boundary qualifiers derived from the current slot.
  always_comb begin
    frame_end_s = (state_r == ST_ON) && (cnt_r == ON_LAST) && (digit_r == DIGIT_LAST);
    commit_s    = frame_end_s && pending_r;
    accept_s    = load && !pending_r;
    ready       = !pending_r;
  end

  // Slot FSM next state: dead gap, then ON, advancing the digit at ON end.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    digit_nx_s = digit_r;
    case (state_r)
      ST_DEAD: begin
        if ((DEAD_CYCLES == 0) || (cnt_r == DEAD_LAST)) begin
          state_nx_s = ST_ON;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s   = cnt_r + CW'(1'b1);
        end
      end
      ST_ON: begin
        if (cnt_r == ON_LAST) begin
          cnt_nx_s   = {CW{1'b0}};
          digit_nx_s = (digit_r == DIGIT_LAST) ? {DW{1'b0}} : digit_r + DW'(1'b1);
          state_nx_s = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;
        end else begin
          cnt_nx_s   = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_nx_s = ST_DEAD;
        cnt_nx_s   = {CW{1'b0}};
        digit_nx_s = {DW{1'b0}};
      end
    endcase
    frame_end_nx_s = (state_nx_s == ST_ON) && (cnt_nx_s == ON_LAST) &&
                     (digit_nx_s == DIGIT_LAST);
  end

  // Outputs are registered from next-cycle values, so the pattern is decoded
  // from the post-commit display to keep an_out and seg_out aligned.
  always_comb begin
    dsp_value_nx_s = commit_s ? sh_value_r : dsp_value_r;
    dsp_dp_nx_s    = commit_s ? sh_dp_r    : dsp_dp_r;
    dsp_blank_nx_s = commit_s ? sh_blank_r : dsp_blank_r;
    nibble_s       = dsp_value_nx_s[{digit_nx_s, 2'b00} +: 4];
  end

  bc_hex u_bc_hex (
    .nibble (nibble_s),
    .seg    (hex_seg_s)
  );

  // Leading-zero suppression: this digit and every higher nibble are zero.
  always_comb begin
    suppress_s = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    suppress_s = (digit_nx_s != {DW{1'b0}});
    for (int k = 0; k < N_DIGITS; k++) begin
      suppress_s = suppress_s &
                   !((k >= int'(digit_nx_s)) && (dsp_value_nx_s[4*k +: 4] != 4'h0));
    end
`endif
  end

  // Per-digit pattern: blank wins over everything, dp survives suppression.
  always_comb begin
    pattern_s = SEG_BLANK;
    if (dsp_blank_nx_s[digit_nx_s]) begin
      pattern_s = SEG_BLANK;
    end else begin
      pattern_s = {dsp_dp_nx_s[digit_nx_s], (suppress_s ? 7'h00 : hex_seg_s)};
    end
  end

  // Slot state, shadow buffer, display buffer and pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_DEAD;
      cnt_r       <= {CW{1'b0}};
      digit_r     <= {DW{1'b0}};
      pending_r   <= 1'b0;
      sh_value_r  <= {VW{1'b0}};
      sh_dp_r     <= {N_DIGITS{1'b0}};
      sh_blank_r  <= {N_DIGITS{1'b0}};
      dsp_value_r <= {VW{1'b0}};
      dsp_dp_r    <= {N_DIGITS{1'b0}};
      dsp_blank_r <= {N_DIGITS{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      digit_r     <= digit_nx_s;
      dsp_value_r <= dsp_value_nx_s;
      dsp_dp_r    <= dsp_dp_nx_s;
      dsp_blank_r <= dsp_blank_nx_s;
      if (accept_s) begin
        sh_value_r <= value_in;
        sh_dp_r    <= dp_in;
        sh_blank_r <= blank_in;
        pending_r  <= 1'b1;
      end else if (commit_s) begin
        pending_r  <= 1'b0;
      end
    end
  end

  // Registered display pins and frame pulse, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= SEG_BLANK;
      an_out     <= {N_DIGITS{1'b0}};
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end_nx_s;
      if (state_nx_s == ST_ON) begin
        seg_out <= pattern_s;
        an_out  <= N_DIGITS'(1'b1) << digit_nx_s;
      end else begin
        seg_out <= SEG_BLANK;
        an_out  <= {N_DIGITS{1'b0}};
      end
    end
  end

endmodule
